// File: rtl/ysyx_23060191_arbiter_pkg.sv
// rtl/ysyx_23060191_arbiter_pkg.sv - shared width and encodings for the IFU/LSU memory arbiter
package ysyx_23060191_arbiter_pkg;

  localparam int CPU_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/ysyx_23060191_arbiter.sv
// rtl/ysyx_23060191_arbiter.sv - single-outstanding IFU/LSU arbiter onto one memory port
module ysyx_23060191_arbiter
  import ysyx_23060191_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIM = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ifu_req_valid,
  output logic                 ifu_req_ready,
  input  logic [CPU_WIDTH-1:0] ifu_addr,
  output logic                 ifu_resp_valid,
  output logic                 ifu_resp_err,
  output logic [CPU_WIDTH-1:0] ifu_rdata,
  input  logic                 lsu_req_valid,
  output logic                 lsu_req_ready,
  input  logic [CPU_WIDTH-1:0] lsu_addr,
  input  logic [CPU_WIDTH-1:0] lsu_wdata,
  input  logic                 lsu_wen,
  input  logic [3:0]           lsu_wmask,
  output logic                 lsu_resp_valid,
  output logic                 lsu_resp_err,
  output logic [CPU_WIDTH-1:0] lsu_rdata,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [CPU_WIDTH-1:0] mem_addr,
  output logic [CPU_WIDTH-1:0] mem_wdata,
  output logic                 mem_wen,
  output logic [3:0]           mem_wmask,
  input  logic                 mem_resp_valid,
  input  logic [CPU_WIDTH-1:0] mem_rdata
);

  localparam int TW = $clog2(TIMEOUT + 1);

  arb_state_t             state_q, state_d;
  arb_owner_t             owner_q;
  logic [CPU_WIDTH-1:0]   addr_q, wdata_q, rdata_q;
  logic                   wen_q, err_q;
  logic [3:0]             wmask_q;
  logic [2:0]             streak_q;
  logic [TW-1:0]          tcnt_q;
  logic                   win_lsu, grant_ifu, grant_lsu, timed_out;

  // LSU is preferred until it has starved a waiting IFU STARVE_LIM times.
  assign win_lsu   = lsu_req_valid && !(ifu_req_valid && (streak_q == 3'(STARVE_LIM)));
  assign grant_lsu = (state_q == ST_IDLE) && win_lsu;
  assign grant_ifu = (state_q == ST_IDLE) && ifu_req_valid && !win_lsu;
  assign timed_out = (tcnt_q == TW'(TIMEOUT - 1)) && !mem_resp_valid;

  assign ifu_req_ready = grant_ifu;
  assign lsu_req_ready = grant_lsu;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (grant_ifu || grant_lsu) state_d = ST_ISSUE;
      ST_ISSUE: if (mem_req_ready) state_d = ST_WAIT;
      ST_WAIT:  if (mem_resp_valid || timed_out) state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_IFU;
      addr_q   <= '0;
      wdata_q  <= '0;
      wen_q    <= 1'b0;
      wmask_q  <= 4'b0000;
      streak_q <= 3'd0;
      tcnt_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;

      if (grant_lsu) begin
        owner_q <= OWN_LSU;
        addr_q  <= lsu_addr;
        wdata_q <= lsu_wdata;
        wen_q   <= lsu_wen;
        wmask_q <= lsu_wmask;
        if (ifu_req_valid && (streak_q != 3'(STARVE_LIM))) streak_q <= streak_q + 3'd1;
      end else if (grant_ifu) begin
        owner_q  <= OWN_IFU;
        addr_q   <= ifu_addr;
        wdata_q  <= '0;
        wen_q    <= 1'b0;
        wmask_q  <= 4'b0000;
        streak_q <= 3'd0;
      end

      if (state_q == ST_ISSUE && mem_req_ready) tcnt_q <= '0;
      else if (state_q == ST_WAIT) tcnt_q <= tcnt_q + TW'(1);

      // Responses are only accepted in WAIT; anything else is stale.
      if (state_q == ST_WAIT) begin
        if (mem_resp_valid) begin
          rdata_q <= mem_rdata;
          err_q   <= 1'b0;
        end else if (timed_out) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
    end
  end

  assign mem_req_valid = (state_q == ST_ISSUE);
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_wen       = wen_q;
  assign mem_wmask     = wmask_q;

  assign ifu_resp_valid = (state_q == ST_RESP) && (owner_q == OWN_IFU);
  assign lsu_resp_valid = (state_q == ST_RESP) && (owner_q == OWN_LSU);
  assign ifu_rdata      = rdata_q;
  assign lsu_rdata      = rdata_q;
  assign ifu_resp_err   = err_q;
  assign lsu_resp_err   = err_q;

endmodule

// File: tb/tb_ysyx_23060191_arbiter.sv
// tb/tb_ysyx_23060191_arbiter.sv - directed self-checking bench for the IFU/LSU arbiter
module tb_ysyx_23060191_arbiter;

  logic        clk, rst_n;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_err;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_err;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask, mem_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  ysyx_23060191_arbiter #(.STARVE_LIM(4), .TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_err(ifu_resp_err), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_wen(lsu_wen), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_err(lsu_resp_err), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Memory model: optional ready stall, then a response one cycle after the handshake.
  logic        model_en, resp_en, hs_prev;
  int          stall_cycles, stall_cnt;
  logic [31:0] rdata_val;

  always @(negedge clk) begin
    if (!model_en) begin
      stall_cnt = 0;
      hs_prev   = 1'b0;
    end else begin
      mem_resp_valid = hs_prev && resp_en;
      mem_rdata      = rdata_val;
      hs_prev        = 1'b0;
      if (mem_req_valid) begin
        if (stall_cnt < stall_cycles) begin
          mem_req_ready = 1'b0;
          stall_cnt++;
        end else begin
          mem_req_ready = 1'b1;
          hs_prev       = 1'b1;
          stall_cnt     = 0;
        end
      end else begin
        mem_req_ready = 1'b0;
      end
    end
  end

  // Monitor: logs grants and response pulses with their cycle numbers.
  int          cyc = 0;
  bit          g_lsu[$];
  int          g_cyc[$];
  int          ifu_resp_cnt = 0, lsu_resp_cnt = 0, last_resp_cyc = 0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0, last_lsu = 1'b0;

  always @(negedge clk) begin
    #3;
    cyc++;
    if (rst_n) begin
      if (ifu_req_valid && ifu_req_ready) begin g_lsu.push_back(1'b0); g_cyc.push_back(cyc); end
      if (lsu_req_valid && lsu_req_ready) begin g_lsu.push_back(1'b1); g_cyc.push_back(cyc); end
      if (ifu_resp_valid) begin
        ifu_resp_cnt++; last_resp_cyc = cyc; last_rdata = ifu_rdata; last_err = ifu_resp_err; last_lsu = 1'b0;
      end
      if (lsu_resp_valid) begin
        lsu_resp_cnt++; last_resp_cyc = cyc; last_rdata = lsu_rdata; last_err = lsu_resp_err; last_lsu = 1'b1;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue_req(input bit is_lsu, input logic [31:0] addr, input logic wen,
                           input logic [31:0] wdata, input logic [3:0] wmask);
    int n0;
    n0 = g_lsu.size();
    if (is_lsu) begin
      lsu_req_valid = 1'b1; lsu_addr = addr; lsu_wen = wen; lsu_wdata = wdata; lsu_wmask = wmask;
    end else begin
      ifu_req_valid = 1'b1; ifu_addr = addr;
    end
    for (int k = 0; k < 50 && g_lsu.size() == n0; k++) step();
    check("grant_arrived", 32'(g_lsu.size() != n0), 32'd1);
    lsu_req_valid = 1'b0; ifu_req_valid = 1'b0;
    lsu_addr = 32'hFFFF_FFF0; ifu_addr = 32'hFFFF_FFF0;
    lsu_wdata = 32'h0; lsu_wmask = 4'hF; lsu_wen = 1'b0;
  endtask

  task automatic wait_resp(input int bound);
    int r0;
    r0 = ifu_resp_cnt + lsu_resp_cnt;
    for (int k = 0; k < bound && (ifu_resp_cnt + lsu_resp_cnt) == r0; k++) step();
    check("resp_arrived", 32'((ifu_resp_cnt + lsu_resp_cnt) != r0), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  bit exp_seq[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  int base, n_i0, n_l0, n_all;

  initial begin
    rst_n = 1'b0;
    ifu_req_valid = 1'b0; ifu_addr = '0;
    lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wen = 1'b0; lsu_wmask = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
    model_en = 1'b0; resp_en = 1'b1; stall_cycles = 0; rdata_val = '0;
    repeat (2) step();
    check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_ifu_resp_valid", 32'(ifu_resp_valid), 32'd0);
    check("rst_lsu_resp_valid", 32'(lsu_resp_valid), 32'd0);
    check("rst_ifu_rdata", ifu_rdata, 32'd0);
    check("rst_lsu_err", 32'(lsu_resp_err), 32'd0);
    rst_n = 1'b1; model_en = 1'b1;
    step();

    // IFU-only fetch with a one-cycle memory
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000; rdata_val = 32'h0000_0413;
    #1;
    check("ifu_only_ready", 32'(ifu_req_ready), 32'd1);
    check("ifu_only_lsu_ready", 32'(lsu_req_ready), 32'd0);
    issue_req(1'b0, 32'h8000_0000, 1'b0, 32'h0, 4'h0);
    check("ifu_mem_valid", 32'(mem_req_valid), 32'd1);
    check("ifu_mem_addr", mem_addr, 32'h8000_0000);
    check("ifu_mem_wen", 32'(mem_wen), 32'd0);
    check("ifu_mem_wmask", 32'(mem_wmask), 32'd0);
    wait_resp(20);
    check("ifu_latency", 32'(last_resp_cyc - g_cyc[$]), 32'd3);
    check("ifu_rdata", last_rdata, 32'h0000_0413);
    check("ifu_err", 32'(last_err), 32'd0);
    check("ifu_owner", 32'(last_lsu), 32'd0);
    step();
    check("ifu_hold_valid", 32'(ifu_resp_valid), 32'd0);
    check("ifu_hold_rdata", ifu_rdata, 32'h0000_0413);

    // Both requesting continuously: LSU x4, IFU, LSU x4, IFU, LSU
    base = g_lsu.size();
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0004;
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0800; lsu_wen = 1'b0; rdata_val = 32'hCAFE_0000;
    for (int k = 0; k < 300 && g_lsu.size() < base + 11; k++) step();
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    check("arb_grant_count", 32'(g_lsu.size() - base), 32'd11);
    for (int i = 0; i < 11 && base + i < g_lsu.size(); i++)
      check($sformatf("arb_seq%0d", i), 32'(g_lsu[base + i]), 32'(exp_seq[i]));
    if (g_cyc.size() >= base + 6)
      check("arb_gap", 32'(g_cyc[base + 5] - g_cyc[base + 4]), 32'd4);
    repeat (6) step();

    // LSU store with a 3-cycle ready stall
    stall_cycles = 3; rdata_val = 32'h5555_AAAA;
    n_l0 = lsu_resp_cnt; n_i0 = ifu_resp_cnt;
    issue_req(1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'b0011);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("st_valid%0d", k), 32'(mem_req_valid), 32'd1);
      check($sformatf("st_addr%0d", k), mem_addr, 32'h8000_1000);
      check($sformatf("st_wdata%0d", k), mem_wdata, 32'hDEAD_BEEF);
      check($sformatf("st_wmask%0d", k), 32'(mem_wmask), 32'h3);
      check($sformatf("st_wen%0d", k), 32'(mem_wen), 32'd1);
      step();
    end
    wait_resp(20);
    repeat (3) step();
    check("st_lsu_resp_cnt", 32'(lsu_resp_cnt - n_l0), 32'd1);
    check("st_ifu_resp_cnt", 32'(ifu_resp_cnt - n_i0), 32'd0);
    check("st_rdata", last_rdata, 32'h5555_AAAA);
    check("st_err", 32'(last_err), 32'd0);
    stall_cycles = 0;

    // No memory response: timeout after 255 WAIT cycles
    resp_en = 1'b0; rdata_val = 32'h7777_7777;
    issue_req(1'b0, 32'h8000_0040, 1'b0, 32'h0, 4'h0);
    wait_resp(400);
    check("to_latency", 32'(last_resp_cyc - g_cyc[$]), 32'd257);
    check("to_err", 32'(last_err), 32'd1);
    check("to_rdata", last_rdata, 32'd0);
    check("to_owner", 32'(last_lsu), 32'd0);
    resp_en = 1'b1; rdata_val = 32'h1234_5678;
    step();
    issue_req(1'b1, 32'h8000_2000, 1'b0, 32'h0, 4'hF);
    wait_resp(20);
    check("after_to_latency", 32'(last_resp_cyc - g_cyc[$]), 32'd3);
    check("after_to_err", 32'(last_err), 32'd0);
    check("after_to_rdata", last_rdata, 32'h1234_5678);
    check("after_to_owner", 32'(last_lsu), 32'd1);

    // Reset during WAIT, late response afterwards
    model_en = 1'b0; mem_req_ready = 1'b1; mem_resp_valid = 1'b0;
    step();
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
    step();
    ifu_req_valid = 1'b0;
    step();
    check("rw_inflight_addr", mem_addr, 32'h8000_0100);
    rst_n = 1'b0;
    #1;
    check("rw_mem_valid", 32'(mem_req_valid), 32'd0);
    check("rw_mem_addr", mem_addr, 32'd0);
    check("rw_ifu_rdata", ifu_rdata, 32'd0);
    check("rw_ifu_resp_valid", 32'(ifu_resp_valid), 32'd0);
    n_all = ifu_resp_cnt + lsu_resp_cnt;
    step();
    rst_n = 1'b1;
    step();
    mem_resp_valid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    step();
    mem_resp_valid = 1'b0;
    repeat (3) step();
    check("rw_no_resp", 32'(ifu_resp_cnt + lsu_resp_cnt - n_all), 32'd0);
    check("rw_rdata_zero", ifu_rdata, 32'd0);
    check("rw_mem_idle", 32'(mem_req_valid), 32'd0);
    ifu_req_valid = 1'b1;
    #1;
    check("rw_idle_ready", 32'(ifu_req_ready), 32'd1);
    ifu_req_valid = 1'b0;

    // Spurious responses in IDLE and ISSUE are ignored
    mem_req_ready = 1'b0;
    step();
    mem_resp_valid = 1'b1; mem_rdata = 32'h1111_1111;
    step();
    mem_resp_valid = 1'b0;
    n_all = ifu_resp_cnt + lsu_resp_cnt;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0200;
    step();
    ifu_req_valid = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h2222_2222;
    step();
    check("sp_still_issue", 32'(mem_req_valid), 32'd1);
    check("sp_no_resp_issue", 32'(ifu_resp_valid), 32'd0);
    mem_resp_valid = 1'b0; mem_req_ready = 1'b1;
    step();
    check("sp_wait_no_resp", 32'(ifu_resp_valid), 32'd0);
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h3333_3333;
    step();
    mem_resp_valid = 1'b0;
    check("sp_resp_valid", 32'(ifu_resp_valid), 32'd1);
    check("sp_rdata", ifu_rdata, 32'h3333_3333);
    check("sp_err", 32'(ifu_resp_err), 32'd0);
    repeat (2) step();
    check("sp_resp_cnt", 32'(ifu_resp_cnt + lsu_resp_cnt - n_all), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
